defuzz_centroid: RTL and testbench
==================================

// Module: defuzz_centroid
// PURPOSE
//  Output end of the fuzzy datapath, the inverse of trapezoid fuzzification.
//  - Accepts a frame of (mu_i, c_i) beats: rule strength in Q1.15 and output singleton in Q7.0.
//  - Produces one crisp Q7.0 value = round(sum(mu_i*c_i) / sum(mu_i)), the weighted-centroid defuzzification.
//  - Sits after rule evaluation/aggregation; feeds the actuator-side consumer.
// PARAMETERS
//  N_MAX        16    max beats per frame; sizes the accumulators
//  DEFAULT_OUT  0     crisp value emitted when sum(mu)==0 (signed 8b)
// PORTS
//  clk        in   1    clock
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    input beat valid
//  in_ready   out  1    block accepts a beat
//  in_mu      in   16   rule strength, unsigned Q1.15 (0x8000 = 1.0)
//  in_c       in   8    singleton position, signed Q7.0
//  in_last    in   1    final beat of frame
//  out_valid  out  1    crisp result valid
//  out_ready  in   1    consumer accepts result
//  out_crisp  out  8    crisp output, signed Q7.0
//  out_empty  out  1    frame had sum(mu)==0; out_crisp = DEFAULT_OUT
//  out_err    out  1    frame had > N_MAX beats; out_crisp undefined
// BEHAVIOUR
//  - Reset values: in_ready=1, out_valid=0, out_crisp=0, out_empty=0, out_err=0.
//  - Reset clears accumulators and the beat counter and forces ACC.
//  - Reset mid-frame discards the partial frame; reset during DIV or OUT drops the pending result.
//  - FSM ACC -> DIV -> FIN -> OUT -> ACC.
//    ACC: in_ready=1.
//      Beat transfers when in_valid & in_ready.
//      num += in_mu*in_c: signed, 24 + clog2(N_MAX+1) bits.
//      den += in_mu: unsigned, 16 + clog2(N_MAX+1) bits.
//      Beat counter saturates at N_MAX+1.
//      Beat with in_last -> DIV.
//    DIV: in_ready=0.
//      Restoring division of |num| by den, 1 quotient bit per cycle, 9 cycles.
//      Result is magnitude in Q8.1: 8 integer bits + 1 rounding bit.
//      Skipped when den==0: the state still lasts 9 cycles, so latency is fixed.
//    FIN: 1 cycle.
//      Round half away from zero: mag = (q + 1) >> 1.
//      Apply sign of num, saturate to [-128, +127].
//      Register out_crisp, out_empty, out_err.
//    OUT: out_valid=1 and in_ready=0.
//      out_crisp, out_empty and out_err are held stable until out_valid & out_ready.
//      Clear accumulators in the handshake cycle; in_ready=1 in the next cycle.
//  - Latency: edge that accepts the last beat = cycle t; out_valid rises at t+11.
//  - Throughput: one frame per (beats + 11 + output stall) cycles; no overlap of frames.
//  - in_mu=0 beats are legal and contribute nothing.
//  - Frame of exactly N_MAX beats: no err.
//  - Single-beat frame with in_last: legal.
//  - den==0 -> out_crisp=DEFAULT_OUT, out_empty=1.
//  - Beats beyond N_MAX: out_err=1, accumulators wrap, out_crisp unspecified.
//  - in_valid while in_ready=0: ignored, no beat consumed.
// STRUCTURE
//  - fuzzy_pkg holds:
//    - typedefs: mu_t = logic [15:0]; crisp_t = logic signed [7:0]
//    - constant MU_ONE = 16'h8000
//    - state enum: ACC, DIV, FIN, OUT
//  - Sub-module seq_udiv: unsigned restoring divider.
//    - Parameters: dividend/divisor widths, QBITS=9.
//    - Handshake: start/done.
//  - Top holds the FSM, accumulators, sign/round/saturate logic.
// TESTING
//  1. One beat: mu=0x8000, c=40, last -> out_crisp=40, out_empty=0; out_valid exactly 11 cycles after accept.
//  2. Two beats: (0x4000,-64), (0x4000,+64) -> out_crisp=0.
//     Two beats: (0x6000,10), (0x2000,50) -> out_crisp=20.
//  3. Rounding: (0x4000,0), (0x4000,1) -> 1; (0x4000,0), (0x4000,-1) -> -1.
//     Saturation: single beat (0x8000,127) -> 127.
//  4. Empty frame: three beats with mu=0 -> out_crisp=DEFAULT_OUT, out_empty=1, same latency.
//  5. Backpressure: out_ready low for 5 cycles -> outputs stable, in_ready=0, extra in_valid ignored.
//     Then on handshake: out_valid=0 and in_ready=1 next cycle.
//  6. rst pulse after 2 of 4 beats, then new frame (0x8000,-100) -> -100.
//     Frame of N_MAX+1 beats -> out_err=1.

Source files
------------

// File: rtl/defuzz_centroid_pkg.sv
`default_nettype none
//============================================================================
// Module      : defuzz_centroid_pkg
// Description : Shared types and constants for the centroid defuzzifier:
//               rule-strength and crisp-value types, the Q1.15 unity
//               constant and the controller state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//============================================================================
package defuzz_centroid_pkg;

    // Rule strength, unsigned Q1.15 (16'h8000 = 1.0)
    typedef logic [15:0] mu_t;

    // Crisp value / singleton position, signed Q7.0
    typedef logic signed [7:0] crisp_t;

    localparam mu_t c_MU_ONE = 16'h8000;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        DIV = 2'd1,
        FIN = 2'd2,
        OUT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/defuzz_centroid_if.sv
`default_nettype none
//============================================================================
// Module      : defuzz_centroid_if
// Description : Beat-in / crisp-out handshake bundle of the defuzzifier.
// Ports       : in_valid/in_ready/in_mu/in_c/in_last  - input beat stream
//               out_valid/out_ready/out_crisp/out_empty/out_err - result
//               modport master : producer/consumer side (testbench, fabric)
//               modport slave  : defuzzifier side
// Revision    : 1.0 - initial release
//============================================================================
interface defuzz_centroid_if;
    import defuzz_centroid_pkg::*;

    logic   in_valid;
    logic   in_ready;
    mu_t    in_mu;
    crisp_t in_c;
    logic   in_last;
    logic   out_valid;
    logic   out_ready;
    crisp_t out_crisp;
    logic   out_empty;
    logic   out_err;

    modport master (
        output in_valid, in_mu, in_c, in_last, out_ready,
        input  in_ready, out_valid, out_crisp, out_empty, out_err
    );

    modport slave (
        input  in_valid, in_mu, in_c, in_last, out_ready,
        output in_ready, out_valid, out_crisp, out_empty, out_err
    );

endinterface
`default_nettype wire

// File: rtl/defuzz_centroid_seq_udiv.sv
`default_nettype none
//============================================================================
// Module      : defuzz_centroid_seq_udiv
// Description : Unsigned restoring divider, one quotient bit per cycle,
//               QBITS quotient bits MSB first. The first bit is resolved in
//               the start cycle, so o_done pulses QBITS cycles after i_start.
//               The dividend must satisfy dividend < divisor << QBITS for
//               the quotient to be exact (true for any legal centroid).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_start             - one-cycle pulse, samples operands
//               i_dividend/i_divisor- operands
//               o_done              - one-cycle pulse, quotient valid
//               o_quotient          - quotient, held until next start
// Revision    : 1.0 - initial release
//============================================================================
module defuzz_centroid_seq_udiv #(
    parameter int DIVIDEND_W = 30,
    parameter int DIVISOR_W  = 21,
    parameter int QBITS      = 9    // must be >= 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_done,
    output logic [QBITS-1:0]      o_quotient
);

    localparam int c_SH_W  = DIVISOR_W + QBITS - 1;
    localparam int c_W     = (DIVIDEND_W > c_SH_W) ? DIVIDEND_W : c_SH_W;
    localparam int c_CNT_W = $clog2(QBITS + 1);

    logic [c_W-1:0]     r_rem;
    logic [c_W-1:0]     r_dsh;
    logic [QBITS-1:0]   r_quo;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [c_W-1:0]     w_rem_src;
    logic [c_W-1:0]     w_dsh_src;
    logic [c_W-1:0]     w_rem_nxt;
    logic               w_ge;

    // The divisor starts aligned to the quotient MSB and walks right one
    // position per cycle; the start cycle works on the fresh operands.
    always_comb begin
        w_rem_src = i_start ? c_W'(i_dividend) : r_rem;
        w_dsh_src = i_start ? (c_W'(i_divisor) << (QBITS - 1)) : r_dsh;
        w_ge      = (w_rem_src >= w_dsh_src);
        w_rem_nxt = w_ge ? (w_rem_src - w_dsh_src) : w_rem_src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_dsh  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= w_rem_nxt;
                r_dsh  <= w_dsh_src >> 1;
                r_quo  <= QBITS'(w_ge);
                r_cnt  <= c_CNT_W'(QBITS - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nxt;
                r_dsh <= r_dsh >> 1;
                r_quo <= QBITS'({r_quo, w_ge});
                r_cnt <= r_cnt - c_CNT_W'(1);
                if (r_cnt == c_CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/defuzz_centroid.sv
`default_nettype none
//============================================================================
// Module      : defuzz_centroid
// Description : Weighted-centroid defuzzifier. Accumulates a frame of
//               (mu, c) beats and emits round(sum(mu*c)/sum(mu)) as a
//               signed Q7.0 crisp value, eleven cycles after the last beat.
// Ports       : clk           - clock
//               rst           - synchronous reset, active-high
//               bus (slave)   - in_valid/in_ready/in_mu/in_c/in_last beat
//                               input; out_valid/out_ready/out_crisp/
//                               out_empty/out_err result output
// Revision    : 1.0 - initial release
//============================================================================
module defuzz_centroid
    import defuzz_centroid_pkg::*;
#(
    parameter int     N_MAX       = 16,
    parameter crisp_t DEFAULT_OUT = 8'sd0
) (
    input  logic             clk,
    input  logic             rst,
    defuzz_centroid_if.slave bus
);

    localparam int c_ACC_EXT = $clog2(N_MAX + 1);
    localparam int c_NUM_W   = 24 + c_ACC_EXT;
    localparam int c_DEN_W   = 16 + c_ACC_EXT;
    localparam int c_PROD_W  = 25;
    localparam int c_CNT_W   = $clog2(N_MAX + 2);
    localparam int c_QBITS   = 9;
    localparam logic [c_CNT_W-1:0] c_CNT_SAT = c_CNT_W'(N_MAX + 1);

    state_t                      r_state;
    logic signed [c_NUM_W-1:0]   r_num;
    logic [c_DEN_W-1:0]          r_den;
    logic [c_CNT_W-1:0]          r_cnt;
    logic                        r_in_ready;
    logic                        r_out_valid;
    crisp_t                      r_crisp;
    logic                        r_empty;
    logic                        r_err;
    logic                        r_div_start;

    logic signed [c_PROD_W-1:0]  w_prod;
    logic                        w_num_neg;
    logic [c_NUM_W-1:0]          w_num_abs;
    logic                        w_div_done;
    logic [c_QBITS-1:0]          w_quo;
    logic [c_QBITS-1:0]          w_mag;
    crisp_t                      w_crisp;
    logic                        w_beat;

    assign w_beat = bus.in_valid && r_in_ready;

    // mu is unsigned: widen with a zero bit so the product stays signed.
    assign w_prod = c_PROD_W'($signed({1'b0, bus.in_mu})) * c_PROD_W'(bus.in_c);

    assign w_num_neg = r_num[c_NUM_W-1];
    assign w_num_abs = w_num_neg ? -r_num : r_num;

    // Dividend is 2*|num| so the quotient lands in Q8.1 (one rounding bit).
    defuzz_centroid_seq_udiv #(
        .DIVIDEND_W (c_NUM_W + 1),
        .DIVISOR_W  (c_DEN_W),
        .QBITS      (c_QBITS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (r_div_start),
        .i_dividend ({w_num_abs, 1'b0}),
        .i_divisor  (r_den),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    // Round half away from zero on the magnitude, then re-apply the sign.
    assign w_mag = c_QBITS'((10'(w_quo) + 10'd1) >> 1);

    always_comb begin
        w_crisp = '0;
        if (!w_num_neg) begin
            w_crisp = (w_mag > 9'd127) ? 8'h7F : w_mag[7:0];
        end else begin
            w_crisp = (w_mag > 9'd128) ? 8'h80 : 8'(9'd0 - w_mag);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACC;
            r_num       <= '0;
            r_den       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_crisp     <= '0;
            r_empty     <= 1'b0;
            r_err       <= 1'b0;
            r_div_start <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                ACC: begin
                    if (w_beat) begin
                        r_num <= r_num + c_NUM_W'(w_prod);
                        r_den <= r_den + c_DEN_W'(bus.in_mu);
                        if (r_cnt != c_CNT_SAT) begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                        if (bus.in_last) begin
                            r_state     <= DIV;
                            r_in_ready  <= 1'b0;
                            r_div_start <= 1'b1;
                        end
                    end
                end
                // The divider always runs so latency is fixed; for an empty
                // frame its quotient is simply discarded in FIN.
                DIV: begin
                    if (w_div_done) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_crisp     <= (r_den == '0) ? DEFAULT_OUT : w_crisp;
                    r_empty     <= (r_den == '0);
                    r_err       <= (r_cnt == c_CNT_SAT);
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_num       <= '0;
                        r_den       <= '0;
                        r_cnt       <= '0;
                        r_state     <= ACC;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_crisp = r_crisp;
    assign bus.out_empty = r_empty;
    assign bus.out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_defuzz_centroid.sv
`default_nettype none
//============================================================================
// Module      : tb_defuzz_centroid
// Description : Scoreboard bench for defuzz_centroid. Frames are driven
//               through the interface; an arithmetic reference model
//               queues the expected crisp/empty/err and result cycle, and
//               an independent monitor pops and compares on each result.
// Ports       : none
// Revision    : 1.0 - initial release
//============================================================================
module tb_defuzz_centroid;
    import defuzz_centroid_pkg::*;

    localparam int     N_MAX = 16;
    localparam crisp_t DEF   = -8'sd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    defuzz_centroid_if bus ();

    defuzz_centroid #(
        .N_MAX       (N_MAX),
        .DEFAULT_OUT (DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int crisp;
        int empty;
        int err;
        int rise;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never
    int   fmu[0:31];
    int   fc[0:31];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference: rounded weighted average, computed directly in wide ints.
    function automatic exp_t model(input int n, input int rise);
        longint num = 0;
        longint den = 0;
        longint mag;
        exp_t   e;
        for (int i = 0; i < n; i++) begin
            num += longint'(fmu[i]) * longint'(fc[i]);
            den += longint'(fmu[i]);
        end
        e.rise  = rise;
        e.err   = (n > N_MAX) ? 1 : 0;
        e.empty = (den == 0) ? 1 : 0;
        if (den == 0) begin
            e.crisp = int'(DEF);
        end else begin
            mag = ((num < 0 ? -num : num) * 2 + den) / (2 * den);
            if (num < 0) mag = -mag;
            if (mag > 127) mag = 127;
            if (mag < -128) mag = -128;
            e.crisp = int'(mag);
        end
        return e;
    endfunction

    // out_ready changes well after the active edge.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic send_beat(input int mu, input int c, input bit last, output int acc_k);
        int w = 0;
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mu    = 16'(mu);
        bus.in_c     = 8'(c);
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) fail_now("in_ready timeout");
        acc_k = cyc;
        @(posedge clk);
    endtask

    task automatic send_frame(input int n);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(fmu[i], fc[i], (i == n - 1), k);
        end
        // Result must appear after the 11th edge following the accepting one.
        sb.push_back(model(n, k + 12));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic frame2(input int m0, input int c0, input int m1, input int c1);
        fmu[0] = m0; fc[0] = c0;
        fmu[1] = m1; fc[1] = c1;
        send_frame(2);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) fail_now("results missing at drain");
    endtask

    // Monitor: latency on rising out_valid, content on handshake,
    // ready/valid turnaround on the cycle after.
    logic prev_valid = 1'b0;
    logic post_hs    = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            post_hs    = 1'b0;
        end else begin
            if (post_hs) begin
                chk("post-handshake out_valid", int'(bus.out_valid), 0);
                chk("post-handshake in_ready", int'(bus.in_ready), 1);
                post_hs = 1'b0;
            end
            if (bus.out_valid && !prev_valid) begin
                if (sb.size() == 0) fail_now("unexpected out_valid");
                else chk("latency", cyc, sb[0].rise);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected result handshake");
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.err == 0) chk("crisp", int'(bus.out_crisp), mon_e.crisp);
                    chk("empty", int'(bus.out_empty), mon_e.empty);
                    chk("err", int'(bus.out_err), mon_e.err);
                end
                post_hs = 1'b1;
            end
            prev_valid = bus.out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL global timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int w;
        bus.in_valid = 1'b0;
        bus.in_mu    = '0;
        bus.in_c     = '0;
        bus.in_last  = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out_crisp", int'(bus.out_crisp), 0);
        chk("reset out_empty", int'(bus.out_empty), 0);
        chk("reset out_err", int'(bus.out_err), 0);
        rst = 1'b0;

        // Single full-strength beat
        fmu[0] = int'(c_MU_ONE); fc[0] = 40;
        send_frame(1);
        frame2(16'h4000, -64, 16'h4000, 64);
        frame2(16'h6000, 10, 16'h2000, 50);
        // Rounding ties, both signs
        frame2(16'h4000, 0, 16'h4000, 1);
        frame2(16'h4000, 0, 16'h4000, -1);
        fmu[0] = int'(c_MU_ONE); fc[0] = 127;
        send_frame(1);
        fmu[0] = int'(c_MU_ONE); fc[0] = -128;
        send_frame(1);
        // Empty frame
        for (int i = 0; i < 3; i++) begin
            fmu[i] = 0;
            fc[i]  = int'($urandom_range(0, 255)) - 128;
        end
        send_frame(3);
        drain();

        // Backpressure: result held, input blocked, stray beats ignored
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        frame2(16'h6000, 10, 16'h2000, 50);
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) fail_now("out_valid timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_mu    = 16'h8000;
            bus.in_c     = 8'sd100;
            bus.in_last  = 1'b1;
            chk("stall out_valid", int'(bus.out_valid), 1);
            chk("stall in_ready", int'(bus.in_ready), 0);
            chk("stall out_crisp", int'(bus.out_crisp), 20);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rdy_mode     = 0;
        drain();

        // Reset mid-frame discards the partial frame
        send_beat(16'h8000, 50, 1'b0, k);
        send_beat(16'h4000, 70, 1'b0, k);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fmu[0] = int'(c_MU_ONE); fc[0] = -100;
        send_frame(1);

        // Exactly N_MAX beats, then one beat too many
        for (int i = 0; i < N_MAX + 1; i++) begin
            fmu[i] = int'($urandom_range(0, 65535));
            fc[i]  = int'($urandom_range(0, 255)) - 128;
        end
        send_frame(N_MAX);
        send_frame(N_MAX + 1);
        drain();

        // Random frames with random output backpressure
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = int'($urandom_range(1, N_MAX));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0:       fmu[i] = 0;
                    1:       fmu[i] = 65535;
                    default: fmu[i] = int'($urandom_range(1, 65535));
                endcase
                fc[i] = int'($urandom_range(0, 255)) - 128;
            end
            send_frame(n);
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
